// File: rtl/vga_pkg.sv
// Shared constants, pixel type, swap FSM states and colour-bar table for the VGA frame server.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int SCALE_SH = 2;
  localparam int FB_W     = H_RES >> SCALE_SH;
  localparam int FB_H     = V_RES >> SCALE_SH;
  localparam int FB_AW    = 15;
  localparam int FB_PIX   = FB_W * FB_H;

  // [3:0]=R, [7:4]=G, [11:8]=B
  typedef logic [11:0] pixel_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } swap_st_e;

  // 16 colour bars of 64 px each; element 0 is the leftmost bar
  localparam logic [15:0][11:0] BAR_LUT = {
    12'h000, 12'hAA0, 12'hA0A, 12'h0AA, 12'hA00, 12'h0A0, 12'h00A, 12'h444,
    12'h888, 12'hFF0, 12'hF0F, 12'h0FF, 12'hF00, 12'h0F0, 12'h00F, 12'hFFF
  };

  // y*FB_W + x written as shifts so it never needs a hard multiplier
  function automatic logic [FB_AW-1:0] fb_offset(input logic [6:0] y, input logic [7:0] x);
    logic [FB_AW-1:0] yw;
    yw = {{(FB_AW-7){1'b0}}, y};
    return (yw << 7) + (yw << 5) + {{(FB_AW-8){1'b0}}, x};
  endfunction

endpackage

// File: rtl/vga_frame_server_if.sv
// Read-request and pixel-write bus between the frame server and its clients.
// Latency: n/a (wires only).
// Backpressure: wr_ready gates write beats; the read side is never stalled.
interface vga_frame_server_if;
  import vga_pkg::*;

  logic [8:0] row;
  logic [9:0] col;
  logic       rdn;
  pixel_t     dout;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  pixel_t     wr_data;

  modport master (output row, col, rdn, wr_valid, wr_x, wr_y, wr_data,
                  input  dout, wr_ready);
  modport slave  (input  row, col, rdn, wr_valid, wr_x, wr_y, wr_data,
                  output dout, wr_ready);
endinterface

// File: rtl/vga_fb_dpram.sv
// Two-bank 160x120x12 framebuffer: one write port, one registered read port (block RAM).
// Latency: read data 1 clk after raddr/re; write lands on the same edge.
// Backpressure: none; callers keep both addresses in range.
module vga_fb_dpram
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [15:0] waddr,
  input  pixel_t      wdata,
  input  logic        re,
  input  logic [15:0] raddr,
  output pixel_t      rdata
);

  // bit 15 selects the bank, bits 14:0 the pixel within it
  pixel_t mem [2][FB_PIX];
  pixel_t rdata_q;

  // write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr[15]][waddr[FB_AW-1:0]] <= wdata;
  end

  // registered read port, holds its last value while re is low
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr[15]][raddr[FB_AW-1:0]];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vga_frame_server.sv
// Double-buffered 4x-upscaled pixel source for the VGA timing generator; optional colour bars under TEST_PATTERN_EN.
// Latency: dout valid 1 clk after row/col/rdn; write lands on the accepting edge.
// Backpressure: wr_ready low from swap_req until the swap completes at the next vs falling edge.
module vga_frame_server
  import vga_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                vs,
  vga_frame_server_if.slave   bus,
  input  logic                swap_req,
  output logic                swap_done,
  output logic [15:0]         frame_cnt
`ifdef TEST_PATTERN_EN
  ,
  input  logic                pat_en
`endif
);

  swap_st_e    state_q;
  logic        front_q;
  logic        swap_done_q;
  logic        wr_ready_q;
  logic        vs_q;
  logic [15:0] frame_cnt_q;
  logic        blank_q;
  logic        blank_d;
  logic        vs_fall;
  logic        rd_ok;
  logic        wr_fire;
  logic        wr_in_range;
  logic        ram_we;
  logic [15:0] rd_addr;
  logic [15:0] wr_addr;
  pixel_t      ram_rdata;
  pixel_t      dout_mux;

  // only in-range, strobed reads touch the RAM; everything else is forced black
  assign rd_ok   = !bus.rdn && (bus.row < 9'(V_RES)) && (bus.col < 10'(H_RES));
  assign blank_d = !rd_ok;
  assign rd_addr = {front_q, fb_offset(7'(bus.row >> SCALE_SH), 8'(bus.col >> SCALE_SH))};

  // out-of-range beats are still consumed, just not written
  assign wr_fire     = bus.wr_valid && wr_ready_q;
  assign wr_in_range = (bus.wr_x < 8'(FB_W)) && (bus.wr_y < 7'(FB_H));
  assign ram_we      = wr_fire && wr_in_range;
  assign wr_addr     = {~front_q, fb_offset(bus.wr_y, bus.wr_x)};

  assign vs_fall = vs_q && !vs;

  vga_fb_dpram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (bus.wr_data),
    .re    (rd_ok),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // blank flag tracks the RAM read register so dout stays black after reset until a real read
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) blank_q <= 1'b1;
    else       blank_q <= blank_d;
  end

`ifdef TEST_PATTERN_EN
  logic   pat_q;
  pixel_t bar_q;

  // colour-bar source registered alongside the RAM so latency matches
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat_q <= 1'b0;
      bar_q <= '0;
    end else begin
      pat_q <= pat_en;
      bar_q <= BAR_LUT[bus.col[9:6]];
    end
  end

  // final pixel select: blanking, then test pattern, then framebuffer
  always_comb begin
    dout_mux = ram_rdata;
    if (pat_q)   dout_mux = bar_q;
    if (blank_q) dout_mux = '0;
  end
`else
  // final pixel select: blanking, then framebuffer
  always_comb begin
    dout_mux = ram_rdata;
    if (blank_q) dout_mux = '0;
  end
`endif

  // vsync edge detector and wrapping frame counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_q        <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vs_q <= vs;
      if (vs_fall) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // swap FSM: arm on swap_req, flip banks on the next vs falling edge, writes stalled meanwhile
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      front_q     <= 1'b0;
      swap_done_q <= 1'b0;
      wr_ready_q  <= 1'b1;
    end else begin
      swap_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (swap_req) begin
            state_q    <= ST_PENDING;
            wr_ready_q <= 1'b0;
          end
        end
        ST_PENDING: begin
          if (vs_fall) begin
            front_q     <= ~front_q;
            swap_done_q <= 1'b1;
            state_q     <= ST_IDLE;
            wr_ready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.dout     = dout_mux;
  assign bus.wr_ready = wr_ready_q;
  assign swap_done    = swap_done_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_frame_server.sv
// Self-checking bench: directed table of reads plus randomized traffic against a framebuffer model.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: model tracks the pending-swap write stall.
module tb_vga_frame_server;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        vs = 1'b1;
  logic        swap_req = 1'b0;
  logic        swap_done;
  logic [15:0] frame_cnt;
`ifdef TEST_PATTERN_EN
  logic        pat_en = 1'b0;
`endif

  vga_frame_server_if bus();

  vga_frame_server dut (
    .clk       (clk),
    .rstn      (rstn),
    .vs        (vs),
    .bus       (bus),
    .swap_req  (swap_req),
    .swap_done (swap_done),
    .frame_cnt (frame_cnt)
`ifdef TEST_PATTERN_EN
    ,
    .pat_en    (pat_en)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: two banks of 120x160 pixels with a written-yet flag
  logic [11:0] fb    [2][120][160];
  bit          known [2][120][160];
  int          m_front, m_pending, m_cnt;
  bit          m_vs_prev, m_swap_done, m_dout_known;
  logic [11:0] m_dout;
  bit          auto_chk = 1'b0;
  logic [11:0] bars [16] = '{12'hFFF, 12'h00F, 12'h0F0, 12'hF00, 12'h0FF, 12'hF0F, 12'hFF0, 12'h888,
                             12'h444, 12'h00A, 12'h0A0, 12'hA00, 12'h0AA, 12'hA0A, 12'hAA0, 12'h000};

  typedef struct {
    int          row;
    int          col;
    bit          rdn;
    logic [11:0] exp;
  } rd_vec_t;
  rd_vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_front = 0; m_pending = 0; m_cnt = 0;
    m_vs_prev = 1'b0; m_swap_done = 1'b0; m_dout = '0; m_dout_known = 1'b1;
  endtask

  // one clock of the specification's rules, using the inputs held across the edge
  task automatic model_step();
    bit fall, rd;
    int y, x;
    fall = m_vs_prev && !vs;
    rd = !bus.rdn && (int'(bus.row) < 480) && (int'(bus.col) < 640);
    m_dout = '0;
    m_dout_known = 1'b1;
    if (rd) begin
      y = int'(bus.row) / 4;
      x = int'(bus.col) / 4;
      m_dout = fb[m_front][y][x];
      m_dout_known = known[m_front][y][x];
    end
`ifdef TEST_PATTERN_EN
    if (rd && pat_en) begin
      m_dout = bars[int'(bus.col) / 64];
      m_dout_known = 1'b1;
    end
`endif
    if (bus.wr_valid && m_pending == 0 && int'(bus.wr_x) < 160 && int'(bus.wr_y) < 120) begin
      fb[1 - m_front][bus.wr_y][bus.wr_x] = bus.wr_data;
      known[1 - m_front][bus.wr_y][bus.wr_x] = 1'b1;
    end
    m_swap_done = 1'b0;
    if (m_pending != 0 && fall) begin
      m_front = 1 - m_front;
      m_pending = 0;
      m_swap_done = 1'b1;
    end else if (m_pending == 0 && swap_req) begin
      m_pending = 1;
    end
    if (fall) m_cnt = (m_cnt + 1) % 65536;
    m_vs_prev = vs;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    if (auto_chk) begin
      if (m_dout_known) check("dout_model", 32'(bus.dout), 32'(m_dout));
      check("wr_ready_model", 32'(bus.wr_ready), 32'(m_pending == 0));
      check("swap_done_model", 32'(swap_done), 32'(m_swap_done));
      check("frame_cnt_model", 32'(frame_cnt), 32'(m_cnt));
    end
  endtask

  task automatic wr_px(input int x, input int y, input logic [11:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_x = 8'(x);
    bus.wr_y = 7'(y);
    bus.wr_data = d;
    cycle();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    cycle();
    swap_req = 1'b0;
    cycle();
    vs = 1'b0;
    cycle();
    vs = 1'b1;
    cycle();
  endtask

  task automatic fill_region();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        wr_px(x, y, 12'($urandom));
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bus.row = '0; bus.col = '0; bus.rdn = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = '0;
    model_reset();

    // reset held while vs toggles and writes are offered
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vs = ~vs;
      @(posedge clk);
    end
    #1;
    check("rst_dout", 32'(bus.dout), 32'h0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'h1);
    check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    check("rst_swap_done", 32'(swap_done), 32'h0);
    bus.wr_valid = 1'b0;
    vs = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    auto_chk = 1'b1;
    cycle();

    // back bank is 1: target pixel, neighbour, alias victim, out-of-range beat
    wr_px(3, 2, 12'hF00);
    wr_px(4, 2, 12'h0A5);
    wr_px(40, 3, 12'h5C3);
    wr_px(200, 2, 12'h123);
    check("oob_wr_ready", 32'(bus.wr_ready), 32'h1);
    swap_req = 1'b1;
    cycle();
    swap_req = 1'b0;
    check("pend_wr_ready", 32'(bus.wr_ready), 32'h0);
    wr_px(40, 3, 12'h777);
    repeat (4) cycle();
    check("pend_hold_ready", 32'(bus.wr_ready), 32'h0);
    vs = 1'b0;
    cycle();
    check("swap_pulse", 32'(swap_done), 32'h1);
    check("swap_ready_back", 32'(bus.wr_ready), 32'h1);
    vs = 1'b1;
    cycle();
    check("swap_pulse_end", 32'(swap_done), 32'h0);

    // directed read table against the newly front bank 1
    for (int r = 8; r < 12; r++)
      for (int c = 12; c < 16; c++)
        tbl.push_back('{r, c, 1'b0, 12'hF00});
    tbl.push_back('{8, 16, 1'b0, 12'h0A5});
    tbl.push_back('{11, 19, 1'b0, 12'h0A5});
    tbl.push_back('{8, 12, 1'b1, 12'h000});
    tbl.push_back('{500, 12, 1'b0, 12'h000});
    tbl.push_back('{8, 700, 1'b0, 12'h000});
    tbl.push_back('{12, 160, 1'b0, 12'h5C3});
    tbl.push_back('{15, 163, 1'b0, 12'h5C3});
    foreach (tbl[i]) begin
      bus.row = 9'(tbl[i].row);
      bus.col = 10'(tbl[i].col);
      bus.rdn = tbl[i].rdn;
      cycle();
      check($sformatf("tbl_rd%0d_r%0d_c%0d", i, tbl[i].row, tbl[i].col), 32'(bus.dout), 32'(tbl[i].exp));
    end
    bus.rdn = 1'b1;
    cycle();

    // swap_req coinciding with vs fall: no swap this frame
    swap_req = 1'b1;
    vs = 1'b0;
    cycle();
    check("coinc_no_swap", 32'(swap_done), 32'h0);
    check("coinc_pending", 32'(bus.wr_ready), 32'h0);
    swap_req = 1'b0;
    vs = 1'b1;
    repeat (4) cycle();
    check("coinc_still_pend", 32'(bus.wr_ready), 32'h0);
    vs = 1'b0;
    cycle();
    check("coinc_swap_next", 32'(swap_done), 32'h1);
    vs = 1'b1;
    cycle();
    bus.row = 9'd8; bus.col = 10'd12; bus.rdn = 1'b0;
    cycle();
    check("coinc_bank0_miss", 32'(bus.dout == 12'hF00), 32'h0);
    bus.rdn = 1'b1;

    // fill a 8x8 region in both banks so random reads hit known pixels
    fill_region();
    do_swap();
    fill_region();

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      vs = ($urandom_range(0, 11) != 0);
      swap_req = ($urandom_range(0, 24) == 0);
      bus.wr_valid = $urandom_range(0, 1) != 0;
      bus.wr_x = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(150, 255)) : 8'($urandom_range(0, 7));
      bus.wr_y = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(100, 127)) : 7'($urandom_range(0, 7));
      bus.wr_data = 12'($urandom);
      bus.rdn = ($urandom_range(0, 3) == 0);
      bus.row = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(470, 511)) : 9'($urandom_range(0, 31));
      bus.col = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(630, 1023)) : 10'($urandom_range(0, 31));
      cycle();
    end
    bus.wr_valid = 1'b0;
    swap_req = 1'b0;
    vs = 1'b1;
    cycle();

    // asynchronous reset mid-cycle with a swap pending and a read in flight
    swap_req = 1'b1;
    bus.rdn = 1'b0; bus.row = 9'd4; bus.col = 10'd4;
    cycle();
    swap_req = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_dout", 32'(bus.dout), 32'h0);
    check("mid_rst_ready", 32'(bus.wr_ready), 32'h1);
    check("mid_rst_swap_done", 32'(swap_done), 32'h0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'h0);
    bus.rdn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vs = ~vs;
      @(posedge clk);
    end
    vs = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    cycle();
    check("post_rst_dout", 32'(bus.dout), 32'h0);
    bus.rdn = 1'b0; bus.row = 9'd0; bus.col = 10'd0;
    cycle();
    bus.rdn = 1'b1;

    // frame counter over many vsync pulses
    for (int i = 0; i < 300; i++) begin
      vs = 1'b0;
      cycle();
      vs = 1'b1;
      cycle();
    end
    check("frame_cnt_300", 32'(frame_cnt), 32'd300);

`ifdef TEST_PATTERN_EN
    pat_en = 1'b1;
    bus.rdn = 1'b0; bus.row = 9'd0; bus.col = 10'd64;
    cycle();
    check("pat_col64", 32'(bus.dout), 32'h00F);
    bus.col = 10'd0;
    cycle();
    check("pat_col0", 32'(bus.dout), 32'hFFF);
    bus.col = 10'd700;
    cycle();
    check("pat_oob", 32'(bus.dout), 32'h000);
    bus.rdn = 1'b1; bus.col = 10'd64;
    cycle();
    check("pat_rdn", 32'(bus.dout), 32'h000);
    pat_en = 1'b0;
    cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
